// File: rtl/pow_chain_pipe.sv
// pow_chain_pipe: fully pipelined power unit. Each accepted argument x yields
// x^1..x^N as one aligned result word, one result per clock, with valid/ready
// flow control on both sides and bubble collapsing.
//
// Configuration macro: POW_CHAIN_PIPE_SAT_EN
//   defined   -> a power that overflowed W bits reads all-ones
//   undefined -> powers wrap (low W bits of the product)
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   arg_vld  argument valid
//   arg_rdy  argument accepted this cycle (combinational)
//   arg      argument x, W bits
//   res_vld  result valid
//   res_rdy  consumer accepts result
//   res      res[(k-1)*W +: W] = x^k, k = 1..N
//   res_ovf  bit k-1 set when x^k exceeded W bits
//   idle     every pipeline stage empty
module pow_chain_pipe #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    output logic             arg_rdy,
    input  logic [W-1:0]     arg,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [N*W-1:0]   res,
    output logic [N-1:0]     res_ovf,
    output logic             idle
);

    localparam int unsigned PW = N * W;
    localparam int unsigned MW = 2 * W;

    logic [N-1:0]  vld;
    logic [N-1:0]  en;
    // The last stage never feeds a multiplier, so it keeps no argument copy.
    logic [W-1:0]  a     [N-1];
    logic [PW-1:0] p     [N];
    logic [PW-1:0] p_nxt [N];
    logic [N-1:0]  o     [N];
    logic [N-1:0]  o_nxt [N];

    // Stage g may load when it is empty or some stage downstream can move;
    // flattened form of the ripple chain en_s = !vld_s | en_{s+1}.
    for (genvar g = 0; g < N; g++) begin : g_en
        assign en[g] = res_rdy | ~(&vld[N-1:g]);
    end

    // Next-state payload for every stage: copy upstream, add one new power.
    always_comb begin
        logic [MW-1:0] m;
        logic          ovf;
        m        = '0;
        ovf      = 1'b0;
        p_nxt[0] = PW'(arg);
        o_nxt[0] = '0;
        for (int i = 1; i < N; i++) begin
            m   = MW'(p[i-1][(i-1)*W +: W]) * MW'(a[i-1]);
            // Sticky: once a lower power overflowed, every higher one has too.
            ovf = o[i-1][i-1] | (m[MW-1:W] != '0);
            p_nxt[i]    = p[i-1];
            o_nxt[i]    = o[i-1];
            o_nxt[i][i] = ovf;
`ifdef POW_CHAIN_PIPE_SAT_EN
            p_nxt[i][i*W +: W] = ovf ? {W{1'b1}} : m[W-1:0];
`else
            p_nxt[i][i*W +: W] = m[W-1:0];
`endif
        end
    end

    // Stage registers; a stage without enable holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < N; i++) begin
                p[i] <= '0;
                o[i] <= '0;
            end
            for (int i = 0; i < N - 1; i++) begin
                a[i] <= '0;
            end
        end else begin
            if (en[0]) begin
                vld[0] <= arg_vld;
                a[0]   <= arg;
            end
            for (int i = 1; i < N; i++) begin
                if (en[i]) begin
                    vld[i] <= vld[i-1];
                end
            end
            for (int i = 1; i < N - 1; i++) begin
                if (en[i]) begin
                    a[i] <= a[i-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    p[i] <= p_nxt[i];
                    o[i] <= o_nxt[i];
                end
            end
        end
    end

    // Ready is forced high during reset so upstream never sees a stale stall.
    assign arg_rdy = rst | en[0];
    assign res_vld = vld[N-1];
    assign res     = p[N-1];
    assign res_ovf = o[N-1];
    assign idle    = ~|vld;

endmodule

// File: tb/tb_pow_chain_pipe.sv
// Self-checking bench for pow_chain_pipe (W=8, N=5): directed latency and
// backpressure scenarios plus randomized traffic checked against a queue-based
// arithmetic model on every cycle.
module tb_pow_chain_pipe;

    localparam int unsigned W = 8;
    localparam int unsigned N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           arg_vld;
    logic           arg_rdy;
    logic [W-1:0]   arg;
    logic           res_vld;
    logic           res_rdy;
    logic [N*W-1:0] res;
    logic [N-1:0]   res_ovf;
    logic           idle;

    int n_checks = 0;
    int n_fail   = 0;
    int out_cnt  = 0;

    logic [W-1:0]   q[$];
    bit             have_hold = 0;
    logic [N*W-1:0] held_res;
    logic [N-1:0]   held_ovf;

    pow_chain_pipe #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .arg     (arg),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res),
        .res_ovf (res_ovf),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact integer powers; overflow means the true power needs more than W bits.
    function automatic logic [N*W-1:0] model_res(input logic [W-1:0] x);
        longint unsigned pw;
        logic [N*W-1:0]  r;
        pw = 1;
        r  = '0;
        for (int k = 0; k < N; k++) begin
            pw = pw * longint'(x);
`ifdef POW_CHAIN_PIPE_SAT_EN
            r[k*W +: W] = (pw >= 256) ? 8'hFF : 8'(pw % 256);
`else
            r[k*W +: W] = 8'(pw % 256);
`endif
        end
        return r;
    endfunction

    function automatic logic [N-1:0] model_ovf(input logic [W-1:0] x);
        longint unsigned pw;
        logic [N-1:0]    f;
        pw = 1;
        f  = '0;
        for (int k = 0; k < N; k++) begin
            pw   = pw * longint'(x);
            f[k] = (pw >= 256);
        end
        return f;
    endfunction

    // Per-cycle compare against the in-order model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("arg_rdy_in_rst", 64'(arg_rdy), 64'd1);
            q.delete();
            have_hold = 0;
        end else begin
            check("arg_rdy", 64'(arg_rdy), 64'(!(q.size() == N && !res_rdy)));
            check("idle", 64'(idle), 64'(q.size() == 0));
            if (res_vld) begin
                if (q.size() == 0) begin
                    check("spurious_res", 64'(res_vld), 64'd0);
                end else begin
                    check("res", 64'(res), 64'(model_res(q[0])));
                    check("res_ovf", 64'(res_ovf), 64'(model_ovf(q[0])));
                end
                if (have_hold) begin
                    check("hold_res", 64'(res), 64'(held_res));
                    check("hold_ovf", 64'(res_ovf), 64'(held_ovf));
                end
            end else if (have_hold) begin
                check("hold_vld", 64'(res_vld), 64'd1);
            end
            have_hold = res_vld && !res_rdy;
            held_res  = res;
            held_ovf  = res_ovf;
            if (res_vld && res_rdy && q.size() > 0) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (arg_vld && arg_rdy) q.push_back(arg);
        end
    end

    // Offer x for up to budget cycles; ok reports whether it was taken.
    task automatic send(input logic [W-1:0] x, input int budget, output bit ok);
        bit taken;
        taken   = 0;
        arg     = x;
        arg_vld = 1'b1;
        for (int i = 0; i < budget && !taken; i++) begin
            @(negedge clk);
            taken = arg_rdy;
            @(posedge clk);
            #1;
        end
        arg_vld = 1'b0;
        ok      = taken;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!idle && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(idle), 64'd1);
    endtask

    initial begin
        bit             ok;
        int             acc;
        int             base;
        int             seen;
        logic [W-1:0]   bp_args [7];
        logic [N*W-1:0] exp3;
        logic [N*W-1:0] exp4;

        rst     = 1'b1;
        arg_vld = 1'b0;
        arg     = '0;
        res_rdy = 1'b1;

        // Model pinned to hand-computed values.
        exp3 = {8'd243, 8'd81, 8'd27, 8'd9, 8'd3};
`ifdef POW_CHAIN_PIPE_SAT_EN
        exp4 = {8'd255, 8'd255, 8'd64, 8'd16, 8'd4};
`else
        exp4 = {8'd0, 8'd0, 8'd64, 8'd16, 8'd4};
`endif
        check("model_3", 64'(model_res(8'd3)), 64'(exp3));
        check("model_3_ovf", 64'(model_ovf(8'd3)), 64'd0);
        check("model_4", 64'(model_res(8'd4)), 64'(exp4));
        check("model_4_ovf", 64'(model_ovf(8'd4)), 64'h18);
        check("model_255_ovf", 64'(model_ovf(8'd255)), 64'h1E);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_res_vld", 64'(res_vld), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_arg_rdy", 64'(arg_rdy), 64'd1);

        // Argument 3: exact latency of N edges after capture.
        send(8'd3, 4, ok);
        check("send_3", 64'(ok), 64'd1);
        repeat (N - 2) @(posedge clk);
        #1;
        check("lat_early", 64'(res_vld), 64'd0);
        @(posedge clk);
        #1;
        check("lat_vld_3", 64'(res_vld), 64'd1);
        check("lat_res_3", 64'(res), 64'(exp3));
        check("lat_ovf_3", 64'(res_ovf), 64'd0);
        wait_idle("idle_after_3");

        // Argument 4: wrap/saturate and overflow flags.
        send(8'd4, 4, ok);
        repeat (N - 1) @(posedge clk);
        #1;
        check("lat_vld_4", 64'(res_vld), 64'd1);
        check("lat_res_4", 64'(res), 64'(exp4));
        check("lat_ovf_4", 64'(res_ovf), 64'h18);
        wait_idle("idle_after_4");

        // Back-to-back stream, one per cycle.
        base = out_cnt;
        foreach (exp3[i]) begin end
        send(8'd0, 2, ok);   check("stream_0", 64'(ok), 64'd1);
        send(8'd1, 1, ok);   check("stream_1", 64'(ok), 64'd1);
        send(8'd2, 1, ok);   check("stream_2", 64'(ok), 64'd1);
        send(8'd255, 1, ok); check("stream_255", 64'(ok), 64'd1);
        wait_idle("idle_after_stream");
        check("stream_count", 64'(out_cnt - base), 64'd4);

        // Backpressure: 7 arguments with the consumer stalled.
        res_rdy = 1'b0;
        base    = out_cnt;
        acc     = 0;
        for (int k = 0; k < 7; k++) bp_args[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 7; k++) begin
            send(bp_args[k], 3, ok);
            if (!ok) break;
            acc++;
        end
        check("bp_accepts", 64'(acc), 64'(N));
        @(negedge clk);
        check("bp_arg_rdy_low", 64'(arg_rdy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        res_rdy = 1'b1;
        for (int k = acc; k < 7; k++) begin
            send(bp_args[k], 10, ok);
            check("bp_late_send", 64'(ok), 64'd1);
        end
        wait_idle("idle_after_bp");
        check("bp_count", 64'(out_cnt - base), 64'd7);

        // Randomized traffic: alternating then random consumer readiness.
        base = out_cnt;
        acc  = 0;
        for (int c = 0; c < 600; c++) begin
            res_rdy = (c < 300) ? 1'(c % 2) : 1'($urandom_range(0, 1));
            arg_vld = 1'($urandom_range(0, 2) != 0);
            arg     = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (arg_vld && arg_rdy) acc++;
            @(posedge clk);
            #1;
        end
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        wait_idle("idle_after_rand");
        check("rand_count", 64'(out_cnt - base), 64'(acc));

        // Reset with 3 items in flight; arg during reset is dropped.
        res_rdy = 1'b0;
        for (int k = 0; k < 3; k++) send(8'(k + 5), 3, ok);
        rst     = 1'b1;
        arg_vld = 1'b1;
        arg     = 8'd77;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        arg_vld = 1'b0;
        check("post_rst_vld", 64'(res_vld), 64'd0);
        check("post_rst_idle", 64'(idle), 64'd1);
        check("post_rst_arg_rdy", 64'(arg_rdy), 64'd1);
        res_rdy = 1'b1;
        seen    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_vld) seen++;
        end
        check("post_rst_no_items", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pow_chain_pipe.md
# pow_chain_pipe

Parametrised, fully pipelined power unit. Each accepted argument `x` produces all powers `x^1 … x^N` together as one aligned result word. Throughput is one result per clock. A valid/ready handshake on both sides gives full backpressure, and bubbles collapse. The block sits in the datapath experiment set as the flow-controlled successor of the fixed 5-stage power pipeline, for use on the DE10-Lite and in simulation.

## Interface
Parameters:
- `W`, default 8: argument and per-power result width in bits (≥2).
- `N`, default 5: number of powers and of pipeline stages (2…8).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `arg_vld`, input, 1: `arg` is valid this cycle.
- `arg_rdy`, output, 1: block accepts `arg` this cycle.
- `arg`, input, W: argument `x`.
- `res_vld`, output, 1: `res` and `res_ovf` are valid.
- `res_rdy`, input, 1: consumer accepts the result this cycle.
- `res`, output, N*W: `res[(k-1)*W +: W]` holds `x^k`, for k = 1…N.
- `res_ovf`, output, N: bit k-1 is set when `x^k` exceeded W bits.
- `idle`, output, 1: high when every pipeline stage is empty.

## Operation
- Stages s = 1…N. Each stage holds `vld_s`, the argument `a_s`, the powers `p_s[1..s]` and the overflow flags `o_s[1..s]`.
- Stage enable: `en_s = !vld_s | en_{s+1}`, with `en_{N+1} = res_rdy`. The enable chain is combinational.
- `arg_rdy = en_1`. A transfer takes place when `arg_vld & arg_rdy`.
- When `en_s` is high, stage s loads everything from stage s-1. For stage 1 it loads from the input: `vld_1 = arg_vld`, `a_1 = arg`, `p_1[1] = arg`, `o_1[1] = 0`.
- Stage s ≥ 2 computes one new power:
  - Full product: `m = p_{s-1}[s-1] * a_{s-1}`, 2W bits wide.
  - Overflow flag: `o_s[s] = o_{s-1}[s-1] | (m[2W-1:W] != 0)`. The flag is sticky along the chain.
  - New power: `p_s[s]` is determined by the configuration macro (see Configuration).
  - Lower powers and flags are copied unchanged from stage s-1.
- When `en_s` is low, stage s holds all of its state.
- Output mapping: `res_vld = vld_N`, `res` = `p_N`, `res_ovf` = `o_N`.
- `idle = ~|{vld_1..vld_N}`.
- Reset (`rst` high at a clock edge):
  - All `vld_s`, `a_s`, `p_s` and `o_s` are cleared to 0, including any in-flight data.
  - During reset, `res_vld = 0`, `res = 0`, `res_ovf = 0`, `idle = 1`, and `arg_rdy = 1` (combinational).
  - An `arg_vld` presented in the same cycle that `rst` is high is dropped.

## Timing
- Latency: an argument accepted at edge T appears with `res_vld = 1` in the cycle after edge T+N-1, i.e. N edges after capture, provided no stall occurs.
- Throughput: one argument per cycle while `res_rdy` stays high.
- Backpressure:
  - When `res_rdy` is low and `vld_N` is high, stage N holds.
  - A bubble in stage s-1 still lets stage s load.
  - `arg_rdy` falls only once all N stages are valid and `res_rdy` is low.
  - Maximum occupancy is N.
- Outputs are stable while `res_vld & !res_rdy`. The consumer is not required to take the result in any given cycle.
- Simultaneous `res_rdy` and `arg_vld` with a full pipe: one result leaves and one argument enters in the same cycle. There are no lost or duplicated items.
- The multiplier is combinational between stage registers. There is one multiply per stage, so a single W×W multiplier is the critical path.

## Configuration
- Macro: `POW_CHAIN_PIPE_SAT_EN`.
- Defined: `p_s[s]` saturates to all-ones (`{W{1'b1}}`) whenever `o_s[s]` is set; otherwise it is `m[W-1:0]`. Because the overflow flag is sticky, all higher powers also read all-ones.
- Undefined: `p_s[s] = m[W-1:0]`, wrap-around truncation.
- `res_ovf` is computed identically in both builds.

## Test plan
- Default W=8, N=5, argument 3 with `res_rdy` held high: after 5 edges, `res` = {243, 81, 27, 9, 3} and `res_ovf` = 0.
- Argument 4, no saturation build: `res` = {0, 0, 64, 16, 4} and `res_ovf` = 5'b11000. With `POW_CHAIN_PIPE_SAT_EN` defined: `res` = {255, 255, 64, 16, 4}.
- Arguments 0, 1, 2, 255 streamed back to back: one result per cycle, in order. For 255: `x^1` = 255 with flag 0, `x^2` and higher flagged.
- Hold `res_rdy` low while streaming 7 arguments:
  - `arg_rdy` drops after 5 accepts.
  - `res` is stable while held.
  - Releasing `res_rdy` drains all 7 results in order, with no duplicates.
- Alternate `res_rdy` 1/0 with `arg_vld` randomly gapped: results match a reference model, and `idle` returns to 1 after the final drain.
- Assert `rst` for 1 cycle with 3 items in flight: the next cycle shows `res_vld` = 0, `idle` = 1, `arg_rdy` = 1, and the old items never appear.
